instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter DATA_W, default 16, width of the instruction word.
REQ-002 Parameter ADDR_W, default 16, width of the fetch address; matches the program counter output.
REQ-003 Parameter TIMEOUT, default 15, maximum REQ cycles waited for mem_ack (1..255).
REQ-004 clock  in  1  system clock; all state changes on posedge.
REQ-005 clear  in  1  asynchronous, active-high reset.
REQ-006 pc_address  in  ADDR_W  current program counter value.
REQ-007 up  out  1  single-cycle increment pulse to the program counter.
REQ-008 halt  in  1  inhibits starting a new fetch.
REQ-009 mem_req  out  1  instruction memory read request.
REQ-010 mem_addr  out  ADDR_W  read address, valid while mem_req=1.
REQ-011 mem_ack  in  1  memory returns data this cycle.
REQ-012 mem_data  in  DATA_W  read data, sampled when mem_ack=1.
REQ-013 ir  out  DATA_W  instruction register to the decoder.
REQ-014 ir_valid  out  1  ir holds an unconsumed instruction.
REQ-015 ir_ready  in  1  decoder accepts ir this cycle.
REQ-016 err  out  1  sticky fetch-timeout flag.

Function
REQ-017 FSM states IDLE, REQ, HOLD, ADV, ERR; all outputs registered.
REQ-018 IDLE: halt=0 -> mem_addr<=pc_address, mem_req<=1, go REQ. halt=1 -> stay IDLE.
REQ-019 REQ: mem_req and mem_addr held stable until mem_ack=1.
REQ-020 REQ with mem_ack=1 -> ir<=mem_data, ir_valid<=1, mem_req<=0, go HOLD; one-cycle minimum latency.
REQ-021 HOLD: ir and ir_valid held; ir_ready=1 -> ir_valid<=0, up<=1, go ADV.
REQ-022 ADV: up=1 for exactly one cycle; next state IDLE with up<=0. The PC updates on the same edge, so IDLE samples the new address.
REQ-023 Exactly one up pulse per accepted instruction; never in any other state.
REQ-024 mem_ack outside REQ is ignored. ir_ready outside HOLD is ignored.
REQ-025 halt asserted in REQ/HOLD/ADV does not abort; it takes effect at the next IDLE.
REQ-026 ir retains its last value after ir_valid drops, until the next capture.

Reset
REQ-027 clear=1 asynchronously forces: state=IDLE, mem_req=0, mem_addr=0, ir=0, ir_valid=0, up=0, err=0, timeout counter=0.
REQ-028 clear mid-REQ drops mem_req immediately. A later stray mem_ack is ignored.
REQ-029 First fetch begins on the first clock edge after clear deasserts, provided halt=0.

Configuration
REQ-030 Macro IFETCH_TIMEOUT_EN defined: counter increments each REQ cycle without mem_ack.
REQ-031 When the counter reaches TIMEOUT, mem_req<=0, err<=1 and the FSM goes to ERR.
REQ-032 ERR is left only by clear.
REQ-033 The counter reloads to 0 on entry to REQ.
REQ-034 Macro undefined: no counter logic, REQ waits indefinitely, err tied 0, ERR unreachable.

Structure
REQ-035 Shared package ifetch_pkg holds the state encoding, the DATA_W/ADDR_W defaults and the TIMEOUT default.
REQ-036 Timeout counter is a sub-module ifetch_watchdog (inputs: start, run, ack; output: expired), instantiated only under IFETCH_TIMEOUT_EN.

Verification
REQ-037 clear pulse, then pc_address=0x0000, mem_ack 1 cycle after req, mem_data=0x1234, ir_ready=1 -> mem_addr=0x0000, ir=0x1234, single up pulse, next mem_addr=0x0004.
REQ-038 ir_ready low 5 cycles in HOLD -> ir_valid high 5+ cycles, ir stable, no up until ready.
REQ-039 halt=1 in IDLE for 3 cycles -> mem_req stays 0; halt=0 -> request issued the next cycle.
REQ-040 clear asserted mid-REQ then mem_ack pulse -> outputs 0 immediately, ack ignored, ir stays 0x0000.
REQ-041 IFETCH_TIMEOUT_EN, TIMEOUT=15, no mem_ack -> err=1 after 15 REQ cycles, mem_req=0, no up; only clear recovers.
REQ-042 Back-to-back fetches with ack and ready always high -> one instruction every 4 cycles, addresses 0x0000, 0x0004, 0x0008.

Source files
------------

// File: rtl/ifetch_pkg.sv
// Shared definitions for the instruction fetch engine: parameter defaults and
// the legacy-compatible FSM state encoding.
package ifetch_pkg;

    localparam int DEF_DATA_W  = 16;
    localparam int DEF_ADDR_W  = 16;
    localparam int DEF_TIMEOUT = 15;

    // Watchdog counter width covers the full 1..255 TIMEOUT range.
    localparam int WDOG_W  = 8;
    localparam int STATE_W = 3;

    typedef logic [STATE_W-1:0] state_t;

    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_REQ  = 3'd1;
    localparam state_t ST_HOLD = 3'd2;
    localparam state_t ST_ADV  = 3'd3;
    localparam state_t ST_ERR  = 3'd4;

endpackage

// File: rtl/ifetch_watchdog.sv
// Fetch-timeout watchdog: counts REQ cycles without mem_ack and flags expiry
// during the TIMEOUT-th such cycle so the FSM can leave REQ on that edge.
module ifetch_watchdog
    import ifetch_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic clock,
    input  logic clear,
    input  logic start,
    input  logic run,
    input  logic ack,
    output logic expired
);

    logic [WDOG_W-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            count <= '0;
        end else if (start) begin
            count <= '0;
        end else if (run && !ack) begin
            count <= count + WDOG_W'(1);
        end
    end

    assign expired = run && !ack && (count == WDOG_W'(TIMEOUT - 1));

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch engine: IDLE -> REQ -> HOLD -> ADV handshake between PC,
// instruction memory and decoder. Define IFETCH_TIMEOUT_EN to add the watchdog.
module instr_fetch
    import ifetch_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic              clock,
    input  logic              clear,
    input  logic [ADDR_W-1:0] pc_address,
    output logic              up,
    input  logic              halt,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_data,
    output logic [DATA_W-1:0] ir,
    output logic              ir_valid,
    input  logic              ir_ready,
    output logic              err
);

    state_t state;
    logic   fetch_start;

    assign fetch_start = (state == ST_IDLE) && !halt;

`ifdef IFETCH_TIMEOUT_EN
    logic wdog_expired;

    ifetch_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clock   (clock),
        .clear   (clear),
        .start   (fetch_start),
        .run     (state == ST_REQ),
        .ack     (mem_ack),
        .expired (wdog_expired)
    );
`else
    assign err = 1'b0;
`endif

    // Asynchronous clear drops mem_req mid-cycle, so memory sees the abort at once.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state    <= ST_IDLE;
            mem_req  <= 1'b0;
            mem_addr <= '0;
            ir       <= '0;
            ir_valid <= 1'b0;
            up       <= 1'b0;
`ifdef IFETCH_TIMEOUT_EN
            err      <= 1'b0;
`endif
        end else begin
            // NOTE: default-low here turns the single assignment in HOLD into a one-cycle pulse.
            up <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (fetch_start) begin
                        mem_addr <= pc_address;
                        mem_req  <= 1'b1;
                        state    <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (mem_ack) begin
                        ir       <= mem_data;
                        ir_valid <= 1'b1;
                        mem_req  <= 1'b0;
                        state    <= ST_HOLD;
                    end
`ifdef IFETCH_TIMEOUT_EN
                    else if (wdog_expired) begin
                        mem_req <= 1'b0;
                        err     <= 1'b1;
                        state   <= ST_ERR;
                    end
`endif
                end
                ST_HOLD: begin
                    if (ir_ready) begin
                        ir_valid <= 1'b0;
                        up       <= 1'b1;
                        state    <= ST_ADV;
                    end
                end
                ST_ADV:  state <= ST_IDLE;
                ST_ERR:  state <= ST_ERR;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed vector table, hand-written corner
// sequences and a randomized run against a transaction-level reference model.
module tb_instr_fetch;

    logic        clock = 1'b0;
    logic        clear = 1'b1;
    logic [15:0] pc = '0;
    logic        up;
    logic        halt = 1'b0;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [15:0] mem_data = '0;
    logic [15:0] ir;
    logic        ir_valid;
    logic        ir_ready = 1'b0;
    logic        err;

    int n_cmp = 0;
    int n_err = 0;

    instr_fetch #(
        .DATA_W  (16),
        .ADDR_W  (16),
        .TIMEOUT (15)
    ) dut (
        .clock      (clock),
        .clear      (clear),
        .pc_address (pc),
        .up         (up),
        .halt       (halt),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_data   (mem_data),
        .ir         (ir),
        .ir_valid   (ir_valid),
        .ir_ready   (ir_ready),
        .err        (err)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        halt;
        logic        ack;
        logic [15:0] data;
        logic        ready;
        logic        e_req;
        logic [15:0] e_addr;
        logic [15:0] e_ir;
        logic        e_iv;
        logic        e_up;
    } vec_t;

    vec_t vecs [12];

    // Reference model state (transaction level)
    logic        m_req, m_iv, m_up;
    logic [15:0] m_ir, m_addr, m_pc;
    logic        n_req, n_iv, n_up;
    logic [15:0] n_ir, n_addr;
    int          wait_cnt;
    int          req_cycles;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, want, $time);
        end
    endtask

    // One clock: inputs already driven; returns at the next negedge. The PC
    // stimulus advances whenever the engine pulses up, like the real counter.
    task automatic cyc();
        @(posedge clock);
        @(negedge clock);
        if (up) pc = pc + 16'd4;
    endtask

    task automatic do_reset();
        clear    = 1'b1;
        halt     = 1'b0;
        mem_ack  = 1'b0;
        mem_data = '0;
        ir_ready = 1'b0;
        pc       = '0;
        repeat (2) @(negedge clock);
        check("rst mem_req", mem_req, 0);
        check("rst mem_addr", mem_addr, 0);
        check("rst ir", ir, 0);
        check("rst ir_valid", ir_valid, 0);
        check("rst up", up, 0);
        check("rst err", err, 0);
        clear = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL sim_timeout: bench did not finish within time limit");
        $fatal(1);
    end

    initial begin
        // Back-to-back fetches, ack and ready always high: 4 cycles per instruction.
        vecs[0]  = '{1'b0, 1'b1, 16'hDEAD, 1'b1, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 16'h1234, 1'b1, 1'b0, 16'h0000, 16'h1234, 1'b1, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 16'hDEAD, 1'b1, 1'b0, 16'h0000, 16'h1234, 1'b0, 1'b1};
        vecs[3]  = '{1'b0, 1'b1, 16'hDEAD, 1'b1, 1'b0, 16'h0000, 16'h1234, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 16'hDEAD, 1'b1, 1'b1, 16'h0004, 16'h1234, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 16'h5678, 1'b1, 1'b0, 16'h0000, 16'h5678, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 16'hDEAD, 1'b1, 1'b0, 16'h0000, 16'h5678, 1'b0, 1'b1};
        vecs[7]  = '{1'b0, 1'b1, 16'hDEAD, 1'b1, 1'b0, 16'h0000, 16'h5678, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 16'hDEAD, 1'b1, 1'b1, 16'h0008, 16'h5678, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 16'h9ABC, 1'b1, 1'b0, 16'h0000, 16'h9ABC, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 16'hDEAD, 1'b1, 1'b0, 16'h0000, 16'h9ABC, 1'b0, 1'b1};
        vecs[11] = '{1'b0, 1'b1, 16'hDEAD, 1'b1, 1'b0, 16'h0000, 16'h9ABC, 1'b0, 1'b0};

        do_reset();
        for (int k = 0; k < 12; k++) begin
            halt     = vecs[k].halt;
            mem_ack  = vecs[k].ack;
            mem_data = vecs[k].data;
            ir_ready = vecs[k].ready;
            cyc();
            check($sformatf("vec%0d mem_req", k), mem_req, vecs[k].e_req);
            if (vecs[k].e_req)
                check($sformatf("vec%0d mem_addr", k), mem_addr, vecs[k].e_addr);
            check($sformatf("vec%0d ir", k), ir, vecs[k].e_ir);
            check($sformatf("vec%0d ir_valid", k), ir_valid, vecs[k].e_iv);
            check($sformatf("vec%0d up", k), up, vecs[k].e_up);
        end

        // Decoder stalls for 5 cycles in HOLD.
        do_reset();
        cyc();
        check("stall mem_req", mem_req, 1);
        mem_ack  = 1'b1;
        mem_data = 16'hA5A5;
        cyc();
        check("stall capture ir", ir, 16'hA5A5);
        check("stall capture valid", ir_valid, 1);
        mem_ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            mem_data = 16'($urandom);
            cyc();
            check($sformatf("stall%0d ir_valid", i), ir_valid, 1);
            check($sformatf("stall%0d ir", i), ir, 16'hA5A5);
            check($sformatf("stall%0d up", i), up, 0);
        end
        ir_ready = 1'b1;
        cyc();
        check("stall accept up", up, 1);
        check("stall accept valid", ir_valid, 0);
        ir_ready = 1'b0;
        cyc();
        check("stall single pulse", up, 0);
        check("stall ir retained", ir, 16'hA5A5);
        cyc();
        check("stall next req", mem_req, 1);
        check("stall next addr", mem_addr, 16'h0004);

        // Halt in IDLE, then clear aborting a live request.
        do_reset();
        halt = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check($sformatf("halt%0d mem_req", i), mem_req, 0);
        end
        halt = 1'b0;
        cyc();
        check("halt release mem_req", mem_req, 1);
        check("halt release addr", mem_addr, 16'h0000);
        halt = 1'b1;
        #2;
        clear = 1'b1;
        #1;
        check("abort mem_req", mem_req, 0);
        check("abort ir_valid", ir_valid, 0);
        check("abort mem_addr", mem_addr, 0);
        @(negedge clock);
        clear    = 1'b0;
        mem_ack  = 1'b1;
        mem_data = 16'hBEEF;
        cyc();
        check("stray ack ir", ir, 16'h0000);
        check("stray ack valid", ir_valid, 0);
        check("stray ack mem_req", mem_req, 0);
        mem_ack = 1'b0;

        // Memory never answers.
        do_reset();
        req_cycles = 0;
        for (int i = 0; i < 30; i++) begin
            cyc();
            if (mem_req) req_cycles++;
            check($sformatf("noack%0d up", i), up, 0);
        end
`ifdef IFETCH_TIMEOUT_EN
        check("timeout req cycles", req_cycles, 15);
        check("timeout err", err, 1);
        check("timeout mem_req", mem_req, 0);
        mem_ack  = 1'b1;
        ir_ready = 1'b1;
        halt     = 1'b0;
        repeat (5) cyc();
        check("err sticky", err, 1);
        check("err no req", mem_req, 0);
        check("err no valid", ir_valid, 0);
        do_reset();
        cyc();
        check("err recovered req", mem_req, 1);
`else
        check("wait req cycles", req_cycles, 30);
        check("wait err", err, 0);
        check("wait mem_req", mem_req, 1);
        mem_ack  = 1'b1;
        mem_data = 16'h0F0F;
        cyc();
        check("late ack ir", ir, 16'h0F0F);
        check("late ack valid", ir_valid, 1);
        mem_ack = 1'b0;
`endif

        // Randomized traffic against the transaction-level model.
        do_reset();
        m_req = 0; m_iv = 0; m_up = 0; m_ir = '0; m_addr = '0; m_pc = '0;
        wait_cnt = 0;
        for (int c = 0; c < 400; c++) begin
            halt     = ($urandom_range(0, 5) == 0);
            mem_ack  = ($urandom_range(0, 2) == 0) || (wait_cnt >= 6);
            mem_data = 16'($urandom);
            ir_ready = ($urandom_range(0, 1) == 1);

            // A request completes on ack; a held instruction leaves on ready;
            // a fully quiet engine starts a fetch at the current PC unless halted.
            n_up = m_iv && ir_ready;
            n_req = m_req; n_iv = m_iv; n_ir = m_ir; n_addr = m_addr;
            if (m_req) begin
                if (mem_ack) begin
                    n_req = 1'b0;
                    n_iv  = 1'b1;
                    n_ir  = mem_data;
                end
            end else if (m_iv) begin
                if (ir_ready) n_iv = 1'b0;
            end else if (!m_up && !halt) begin
                n_req  = 1'b1;
                n_addr = m_pc;
            end
            wait_cnt = n_req ? wait_cnt + 1 : 0;

            cyc();
            m_req = n_req; m_iv = n_iv; m_ir = n_ir; m_addr = n_addr; m_up = n_up;
            if (m_up) m_pc = m_pc + 16'd4;

            check($sformatf("rnd%0d mem_req", c), mem_req, m_req);
            if (m_req)
                check($sformatf("rnd%0d mem_addr", c), mem_addr, m_addr);
            check($sformatf("rnd%0d ir_valid", c), ir_valid, m_iv);
            check($sformatf("rnd%0d ir", c), ir, m_ir);
            check($sformatf("rnd%0d up", c), up, m_up);
            check($sformatf("rnd%0d err", c), err, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
